// File: rtl/exe_pkg.sv
// Shared constants for the execute stage: bus widths, opcode/funct codes, divider states.
// Latency: n/a (constants and pure helper function only).
// Backpressure: n/a.
package exe_pkg;

  localparam int RDATA_WIDTH = 32;
  localparam int RADDR_WIDTH = 5;
  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 32;

  localparam logic [RDATA_WIDTH-1:0] ZERO          = '0;
  localparam logic [DATA_WIDTH-1:0]  NOP           = 32'h0000_0001;
  localparam logic                   WRITE_DISABLE = 1'b0;

  // Opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // ALU funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // M-extension funct3 (divides are the upper half, funct3[2]=1)
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  localparam logic [6:0] MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic is_div_inst(input logic [DATA_WIDTH-1:0] inst);
    return (inst[6:0] == OPC_OP) && (inst[31:25] == MULDIV) && inst[14];
  endfunction

endpackage

// File: rtl/exe_div.sv
// Iterative radix-2 restoring divider on magnitudes with sign fix-up on the outputs.
// Latency: start accepted in IDLE, DIV_STEPS cycles in BUSY, result valid for one DONE cycle.
// Backpressure: none; start is only looked at in IDLE, caller holds operands steady.
// Ports: clk_i/rst_i (sync, active high), start, is_signed, op1 (dividend), op2 (divisor),
//        busy, done, quotient, remainder.
module exe_div
  import exe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_STEPS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(DIV_STEPS);

  div_state_e      state;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dsr;
  logic            neg_q;
  logic            neg_r;

  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            ge;

  // |0x80000000| stays 0x80000000, which is correct read as unsigned.
  assign a_abs = (is_signed && op1[XLEN-1]) ? -op1 : op1;
  assign b_abs = (is_signed && op2[XLEN-1]) ? -op2 : op2;

  // Next dividend bit shifts out of the quotient register into the partial remainder.
  assign rem_sh = {rem, quo[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dsr};
  assign ge     = ~diff[XLEN];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= DIV_IDLE;
      count <= '0;
      quo   <= '0;
      rem   <= '0;
      dsr   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            quo   <= a_abs;
            rem   <= '0;
            dsr   <= b_abs;
            neg_q <= is_signed & (op1[XLEN-1] ^ op2[XLEN-1]);
            neg_r <= is_signed & op1[XLEN-1];
            count <= '0;
            state <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          quo   <= {quo[XLEN-2:0], ge};
          rem   <= ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
          count <= count + CW'(1);
          if (count == CW'(DIV_STEPS - 1)) state <= DIV_DONE;
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

  assign busy      = (state == DIV_BUSY);
  assign done      = (state == DIV_DONE);
  assign quotient  = neg_q ? -quo : quo;
  assign remainder = neg_r ? -rem : rem;

endmodule

// File: rtl/exe.sv
// RV32IM execute stage: ALU, branch/jump redirect, single-cycle MUL, iterative DIV.
// Latency: 0 cycles for everything except non-trivial divides (33 stall cycles, result in cycle 34).
// Backpressure: stall_req_o asks the HDU to freeze IF/ID/ID_EXE while the divider runs.
// Ports: clk_i/rst_i (sync, active high); op1_i/op2_i operands, reg_we_i/reg_waddr_i,
//        inst_i/inst_addr_i from ID/EXE; reg_wdata_o/reg_we_o/reg_waddr_o to EXE/MEM;
//        jump_en_o/jump_addr_o/stall_req_o to the HDU.
module exe
  import exe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_STEPS = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [RDATA_WIDTH-1:0] op1_i,
  input  logic [RDATA_WIDTH-1:0] op2_i,
  input  logic                   reg_we_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic [DATA_WIDTH-1:0]  inst_i,
  input  logic [ADDR_WIDTH-1:0]  inst_addr_i,
  output logic [RDATA_WIDTH-1:0] reg_wdata_o,
  output logic                   reg_we_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   jump_en_o,
  output logic [ADDR_WIDTH-1:0]  jump_addr_o,
  output logic                   stall_req_o
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_u, imm_j, imm_b;
  logic [4:0]      shamt;
  logic            sub_en;
  logic [XLEN-1:0] sum_jalr;

  assign opcode   = inst_i[6:0];
  assign f3       = inst_i[14:12];
  assign f7       = inst_i[31:25];
  assign imm_u    = {inst_i[31:12], 12'b0};
  assign imm_j    = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_b    = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign shamt    = op2_i[4:0];
  // OP-IMM reuses inst[30] as an immediate bit, so only R-type may subtract.
  assign sub_en   = (opcode == OPC_OP) && inst_i[30];
  assign sum_jalr = op1_i + op2_i;

  // 33x33 signed product; extending both operands to 64 bits keeps the low 64 bits exact.
  logic            s1, s2;
  logic [2*XLEN-1:0] ma, mb, prod;
  assign s1   = (f3 == F3_MULH) || (f3 == F3_MULHSU);
  assign s2   = (f3 == F3_MULH);
  assign ma   = {{XLEN{s1 & op1_i[XLEN-1]}}, op1_i};
  assign mb   = {{XLEN{s2 & op2_i[XLEN-1]}}, op2_i};
  assign prod = ma * mb;

  // Divide control; divisor-zero and signed overflow resolve without starting the divider.
  logic            is_div, div_sgn, div_zero, div_ovf, div_start;
  logic            div_busy, div_done;
  logic [XLEN-1:0] div_q, div_r, q_sel, r_sel, div_res;

  assign is_div    = is_div_inst(inst_i);
  assign div_sgn   = ~f3[0];
  assign div_zero  = (op2_i == '0);
  assign div_ovf   = div_sgn && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
  assign div_start = is_div && !div_zero && !div_ovf;

  exe_div #(.XLEN(XLEN), .DIV_STEPS(DIV_STEPS)) u_div (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start     (div_start),
    .is_signed (div_sgn),
    .op1       (op1_i),
    .op2       (op2_i),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_comb begin
    q_sel = div_q;
    r_sel = div_r;
    if (div_zero) begin
      q_sel = '1;
      r_sel = op1_i;
    end else if (div_ovf) begin
      q_sel = {1'b1, {(XLEN-1){1'b0}}};
      r_sel = '0;
    end
  end
  assign div_res = f3[1] ? r_sel : q_sel;

  logic [XLEN-1:0] alu_res, md_res, result, jaddr;
  logic            br_taken, jen, stall;

  always_comb begin
    alu_res = ZERO;
    case (f3)
      F3_ADD:  alu_res = sub_en ? op1_i - op2_i : op1_i + op2_i;
      F3_SLL:  alu_res = op1_i << shamt;
      F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
      F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, op1_i < op2_i};
      F3_XOR:  alu_res = op1_i ^ op2_i;
      F3_SR:   alu_res = inst_i[30] ? $unsigned($signed(op1_i) >>> shamt) : op1_i >> shamt;
      F3_OR:   alu_res = op1_i | op2_i;
      F3_AND:  alu_res = op1_i & op2_i;
      default: alu_res = ZERO;
    endcase

    md_res = div_res;
    case (f3)
      F3_MUL:                        md_res = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  md_res = prod[2*XLEN-1:XLEN];
      default:                       md_res = div_res;
    endcase

    br_taken = 1'b0;
    case (f3)
      F3_BEQ:  br_taken = (op1_i == op2_i);
      F3_BNE:  br_taken = (op1_i != op2_i);
      F3_BLT:  br_taken = $signed(op1_i) < $signed(op2_i);
      F3_BGE:  br_taken = $signed(op1_i) >= $signed(op2_i);
      F3_BLTU: br_taken = op1_i < op2_i;
      F3_BGEU: br_taken = op1_i >= op2_i;
      default: br_taken = 1'b0;
    endcase

    result = ZERO;
    jen    = 1'b0;
    jaddr  = ZERO;
    case (opcode)
      OPC_OP:     result = (f7 == MULDIV) ? md_res : alu_res;
      OPC_OP_IMM: result = alu_res;
      OPC_LUI:    result = imm_u;
      OPC_AUIPC:  result = inst_addr_i + imm_u;
      OPC_JAL: begin
        result = inst_addr_i + 32'd4;
        jen    = 1'b1;
        jaddr  = inst_addr_i + imm_j;
      end
      OPC_JALR: begin
        result = inst_addr_i + 32'd4;
        jen    = 1'b1;
        jaddr  = {sum_jalr[XLEN-1:1], 1'b0};
      end
      OPC_BRANCH: begin
        jen = br_taken;
        if (br_taken) jaddr = inst_addr_i + imm_b;
      end
      default: ;
    endcase
  end

  // Stall covers the accepting IDLE cycle plus every BUSY cycle; DONE is not stalled.
  assign stall = div_busy || (div_start && !div_busy && !div_done);

  assign stall_req_o = rst_i ? 1'b0 : stall;
  assign reg_we_o    = (rst_i || stall) ? WRITE_DISABLE : reg_we_i;
  assign reg_waddr_o = reg_waddr_i;
  assign reg_wdata_o = rst_i ? ZERO : result;
  assign jump_en_o   = rst_i ? 1'b0 : jen;
  assign jump_addr_o = rst_i ? ZERO : jaddr;

endmodule

// File: tb/tb_exe.sv
module tb_exe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] op1_i, op2_i, inst_i, inst_addr_i;
  logic        reg_we_i;
  logic [4:0]  reg_waddr_i;
  logic [31:0] reg_wdata_o, jump_addr_o;
  logic        reg_we_o, jump_en_o, stall_req_o;
  logic [4:0]  reg_waddr_o;

  exe dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .reg_we_i    (reg_we_i),
    .reg_waddr_i (reg_waddr_i),
    .inst_i      (inst_i),
    .inst_addr_i (inst_addr_i),
    .reg_wdata_o (reg_wdata_o),
    .reg_we_o    (reg_we_o),
    .reg_waddr_o (reg_waddr_o),
    .jump_en_o   (jump_en_o),
    .jump_addr_o (jump_addr_o),
    .stall_req_o (stall_req_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111, JALR = 7'b1100111;
  localparam logic [31:0] NOP = 32'h0000_0001;

  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, OP};
  endfunction
  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [2:0] f3, input logic [6:0] op);
    return {imm, 5'd1, f3, 5'd3, op};
  endfunction
  function automatic logic [31:0] u_t(input logic [19:0] imm, input logic [6:0] op);
    return {imm, 5'd3, op};
  endfunction
  function automatic logic [31:0] j_t(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction
  function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] inst, op1, op2, pc;
    logic        we;
    logic [31:0] e_wd;
    logic        e_we, e_je;
    logic [31:0] e_ja;
    logic        e_st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] inst, op1, op2, pc, input logic we,
                              input logic [31:0] e_wd, input logic e_we, e_je,
                              input logic [31:0] e_ja, input logic e_st);
    vec_t v;
    v.inst = inst; v.op1 = op1; v.op2 = op2; v.pc = pc; v.we = we;
    v.e_wd = e_wd; v.e_we = e_we; v.e_je = e_je; v.e_ja = e_ja; v.e_st = e_st;
    return v;
  endfunction

  task automatic drive(input logic [31:0] inst, op1, op2, pc, input logic we);
    inst_i = inst; op1_i = op1; op2_i = op2; inst_addr_i = pc; reg_we_i = we;
  endtask

  // Runs one stalling divide from an IDLE cycle; ends one edge after the DONE cycle.
  task automatic run_div(input string nm, input logic [2:0] f3, input logic [31:0] a, b, exp);
    int n;
    drive(r_t(7'b0000001, f3), a, b, 32'h300, 1'b1);
    #1;
    chk({nm, " we_during_stall"}, {31'b0, reg_we_o}, 32'd0);
    n = 0;
    while (stall_req_o && n < 40) begin
      n++;
      @(posedge clk_i); #1;
    end
    chk({nm, " stall_cycles"}, n, 33);
    chk({nm, " result"}, reg_wdata_o, exp);
    chk({nm, " we_done"}, {31'b0, reg_we_o}, 32'd1);
    @(posedge clk_i); #1;
  endtask

  initial begin
    rst_i = 1'b1; reg_waddr_i = 5'd3;
    drive(j_t(21'h20), 32'd5, 32'd7, 32'h100, 1'b1);
    @(posedge clk_i); @(posedge clk_i); #1;
    chk("rst wdata", reg_wdata_o, 32'd0);
    chk("rst we", {31'b0, reg_we_o}, 32'd0);
    chk("rst jump_en", {31'b0, jump_en_o}, 32'd0);
    chk("rst jump_addr", jump_addr_o, 32'd0);
    chk("rst stall", {31'b0, stall_req_o}, 32'd0);
    rst_i = 1'b0;

    vecs.push_back(mk(r_t(7'h00, 3'b000), 32'd5, 32'd7, 32'h100, 1, 32'd12, 1, 0, 0, 0));
    vecs.push_back(mk(r_t(7'h20, 3'b000), 32'd5, 32'd7, 32'h100, 1, 32'hFFFF_FFFE, 1, 0, 0, 0));
    vecs.push_back(mk(i_t(12'h400, 3'b000, OPI), 32'd1, 32'h400, 32'h100, 1, 32'h401, 1, 0, 0, 0));
    vecs.push_back(mk(r_t(7'h00, 3'b001), 32'd1, 32'h25, 32'h100, 1, 32'd32, 1, 0, 0, 0));
    vecs.push_back(mk(r_t(7'h00, 3'b010), 32'hFFFF_FFFF, 32'd1, 32'h100, 1, 32'd1, 1, 0, 0, 0));
    vecs.push_back(mk(r_t(7'h00, 3'b011), 32'hFFFF_FFFF, 32'd1, 32'h100, 1, 32'd0, 1, 0, 0, 0));
    vecs.push_back(mk(r_t(7'h00, 3'b100), 32'hF0F0, 32'h0FF0, 32'h100, 1, 32'hFF00, 1, 0, 0, 0));
    vecs.push_back(mk(r_t(7'h00, 3'b101), 32'h8000_0000, 32'd4, 32'h100, 1, 32'h0800_0000, 1, 0, 0, 0));
    vecs.push_back(mk(r_t(7'h20, 3'b101), 32'h8000_0000, 32'd4, 32'h100, 1, 32'hF800_0000, 1, 0, 0, 0));
    vecs.push_back(mk(i_t(12'h404, 3'b101, OPI), 32'h8000_0000, 32'h404, 32'h100, 1, 32'hF800_0000, 1, 0, 0, 0));
    vecs.push_back(mk(r_t(7'h00, 3'b110), 32'hF0F0, 32'h0FF0, 32'h100, 1, 32'hFFF0, 1, 0, 0, 0));
    vecs.push_back(mk(r_t(7'h00, 3'b111), 32'hF0F0, 32'h0FF0, 32'h100, 1, 32'h00F0, 1, 0, 0, 0));
    vecs.push_back(mk(u_t(20'h12345, LUI), 32'd9, 32'd9, 32'h1000, 1, 32'h1234_5000, 1, 0, 0, 0));
    vecs.push_back(mk(u_t(20'h12345, AUIPC), 32'd9, 32'd9, 32'h1000, 1, 32'h1234_6000, 1, 0, 0, 0));
    vecs.push_back(mk(j_t(21'h20), 32'd0, 32'd0, 32'h100, 1, 32'h104, 1, 1, 32'h120, 0));
    vecs.push_back(mk(i_t(12'h004, 3'b000, JALR), 32'h1001, 32'd4, 32'h200, 1, 32'h204, 1, 1, 32'h1004, 0));
    vecs.push_back(mk(b_t(13'h1FF0, 3'b000), 32'd9, 32'd9, 32'h100, 0, 32'd0, 0, 1, 32'hF0, 0));
    vecs.push_back(mk(b_t(13'h1FF0, 3'b000), 32'd9, 32'd8, 32'h100, 0, 32'd0, 0, 0, 0, 0));
    vecs.push_back(mk(b_t(13'h0040, 3'b001), 32'd1, 32'd2, 32'h100, 0, 32'd0, 0, 1, 32'h140, 0));
    vecs.push_back(mk(b_t(13'h0008, 3'b100), 32'hFFFF_FFFF, 32'd1, 32'h100, 0, 32'd0, 0, 1, 32'h108, 0));
    vecs.push_back(mk(b_t(13'h1FFC, 3'b101), 32'd5, 32'd5, 32'h100, 0, 32'd0, 0, 1, 32'hFC, 0));
    vecs.push_back(mk(b_t(13'h0010, 3'b110), 32'd1, 32'hFFFF_FFFF, 32'h100, 0, 32'd0, 0, 1, 32'h110, 0));
    vecs.push_back(mk(b_t(13'h0010, 3'b111), 32'd1, 32'hFFFF_FFFF, 32'h100, 0, 32'd0, 0, 0, 0, 0));
    vecs.push_back(mk(r_t(7'h01, 3'b000), 32'd3, 32'hFFFF_FFFE, 32'h100, 1, 32'hFFFF_FFFA, 1, 0, 0, 0));
    vecs.push_back(mk(r_t(7'h01, 3'b001), 32'h4000_0000, 32'd4, 32'h100, 1, 32'd1, 1, 0, 0, 0));
    vecs.push_back(mk(r_t(7'h01, 3'b001), 32'hFFFF_FFFE, 32'd3, 32'h100, 1, 32'hFFFF_FFFF, 1, 0, 0, 0));
    vecs.push_back(mk(r_t(7'h01, 3'b010), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h100, 1, 32'hFFFF_FFFF, 1, 0, 0, 0));
    vecs.push_back(mk(r_t(7'h01, 3'b011), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h100, 1, 32'hFFFF_FFFE, 1, 0, 0, 0));
    vecs.push_back(mk(NOP, 32'd5, 32'd7, 32'h100, 1, 32'd0, 1, 0, 0, 0));
    vecs.push_back(mk(r_t(7'h01, 3'b100), 32'd42, 32'd0, 32'h100, 1, 32'hFFFF_FFFF, 1, 0, 0, 0));
    vecs.push_back(mk(r_t(7'h01, 3'b111), 32'd42, 32'd0, 32'h100, 1, 32'd42, 1, 0, 0, 0));
    vecs.push_back(mk(r_t(7'h01, 3'b100), 32'h8000_0000, 32'hFFFF_FFFF, 32'h100, 1, 32'h8000_0000, 1, 0, 0, 0));
    vecs.push_back(mk(r_t(7'h01, 3'b110), 32'h8000_0000, 32'hFFFF_FFFF, 32'h100, 1, 32'd0, 1, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].inst, vecs[i].op1, vecs[i].op2, vecs[i].pc, vecs[i].we);
      #1;
      chk($sformatf("vec%0d wdata", i), reg_wdata_o, vecs[i].e_wd);
      chk($sformatf("vec%0d we", i), {31'b0, reg_we_o}, {31'b0, vecs[i].e_we});
      chk($sformatf("vec%0d jump_en", i), {31'b0, jump_en_o}, {31'b0, vecs[i].e_je});
      if (vecs[i].e_je) chk($sformatf("vec%0d jump_addr", i), jump_addr_o, vecs[i].e_ja);
      chk($sformatf("vec%0d stall", i), {31'b0, stall_req_o}, {31'b0, vecs[i].e_st});
      chk($sformatf("vec%0d waddr", i), {27'b0, reg_waddr_o}, 32'd3);
      @(posedge clk_i); #1;
    end

    // Back-to-back divides: each starts on the cycle right after the previous DONE.
    run_div("divu", 3'b101, 32'd100, 32'd7, 32'd14);
    run_div("remu", 3'b111, 32'd100, 32'd7, 32'd2);
    run_div("div",  3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA);
    run_div("rem",  3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE);
    run_div("divu_big", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    drive(NOP, 32'd0, 32'd0, 32'h100, 1'b1);
    @(posedge clk_i); #1;

    // Reset in the middle of a divide aborts it with no writeback.
    drive(r_t(7'h01, 3'b101), 32'd100, 32'd7, 32'h300, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_i); #1;
    end
    chk("abort pre stall", {31'b0, stall_req_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("abort rst stall", {31'b0, stall_req_o}, 32'd0);
    chk("abort rst we", {31'b0, reg_we_o}, 32'd0);
    @(posedge clk_i); #1;
    drive(NOP, 32'd0, 32'd0, 32'h100, 1'b1);
    rst_i = 1'b0;
    #1;
    chk("abort idle stall", {31'b0, stall_req_o}, 32'd0);
    chk("abort idle we", {31'b0, reg_we_o}, 32'd1);
    @(posedge clk_i); #1;
    run_div("divu_after_abort", 3'b101, 32'd9, 32'd3, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
